// File: rtl/sprite_eval_scheduler.sv
// sprite_eval_scheduler
// Per-scanline sprite evaluation and pattern-fetch sequencer for the PPU.
// A start pulse scans NUM_ENTRIES OAM words (one per cycle, pipelined by the
// one-cycle OAM read latency) and keeps up to MAX_SPRITES hits in OAM order.
// Each kept hit's pattern row is then fetched from sprite_graphics and
// presented as one slot-load write per hit, back to back.
// Optional build macro: SPRITE_VFLIP_EN (OAM bit 29 mirrors the fetched row).
module sprite_eval_scheduler #(
    parameter int NUM_ENTRIES = 64,
    parameter int MAX_SPRITES = 8,
    parameter int SPRITE_H    = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [9:0]  line_i,
    output logic [7:0]  oam_addr_o,
    input  logic [31:0] oam_rdata_i,
    output logic [10:0] gfx_addr_o,
    input  logic [31:0] gfx_rdata_i,
    output logic        slot_we_o,
    output logic [2:0]  slot_idx_o,
    output logic [31:0] slot_pattern_o,
    output logic [9:0]  slot_x_o,
    output logic [2:0]  slot_palette_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  sprite_count_o,
    output logic        overflow_o
);

    localparam int ROW_W = $clog2(SPRITE_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0] tile;
        logic [3:0] row;
        logic [9:0] x;
        logic [2:0] pal;
    } hit_t;

    state_t      state_q, state_d;
    logic [9:0]  line_q, line_d;
    logic [8:0]  scan_cnt_q, scan_cnt_d;
    logic [3:0]  fetch_cnt_q, fetch_cnt_d;
    logic [3:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [10:0] gfx_addr_q, gfx_addr_d;
    logic        slot_we_q, slot_we_d;
    logic [2:0]  slot_idx_q, slot_idx_d;
    logic [9:0]  slot_x_q, slot_x_d;
    logic [2:0]  slot_pal_q, slot_pal_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    hit_t        list_q [MAX_SPRITES];
    hit_t        list_d [MAX_SPRITES];

    logic [10:0] diff_s;
    logic        hit_s;
    logic [3:0]  row_s;
    hit_t        entry_s;
    logic        scan_end_s;
    logic [3:0]  fetch_nxt_s;
    logic        unused_oam_bits_s;

    // Hit test on the OAM word returned for the previous address: signed
    // 11-bit distance from sprite top, so lines above y never wrap into a hit.
    always_comb begin
        diff_s = {1'b0, line_q} - {2'b00, oam_rdata_i[8:0]};
        hit_s  = oam_rdata_i[31] && !diff_s[10] && (diff_s[9:ROW_W] == '0);
`ifdef SPRITE_VFLIP_EN
        if (oam_rdata_i[29]) begin
            row_s = 4'd15 - diff_s[3:0];
        end else begin
            row_s = diff_s[3:0];
        end
`else
        row_s = diff_s[3:0];
`endif
        entry_s.tile = oam_rdata_i[25:19];
        entry_s.row  = row_s;
        entry_s.x    = oam_rdata_i[18:9];
        entry_s.pal  = oam_rdata_i[28:26];
    end

    // Bit 30 is never used; bit 29 only matters when vertical flip is built in.
    assign unused_oam_bits_s = ^{oam_rdata_i[30], oam_rdata_i[29]};

    // Next-state and next-output logic for the IDLE/SCAN/FETCH/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        scan_cnt_d  = scan_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        oam_addr_d  = oam_addr_q;
        gfx_addr_d  = gfx_addr_q;
        slot_we_d   = 1'b0;
        slot_idx_d  = slot_idx_q;
        slot_x_d    = slot_x_q;
        slot_pal_d  = slot_pal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        list_d      = list_q;
        scan_end_s  = 1'b0;
        fetch_nxt_s = fetch_cnt_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    line_d     = line_i;
                    count_d    = 4'd0;
                    overflow_d = 1'b0;
                    oam_addr_d = 8'd0;
                    scan_cnt_d = 9'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                scan_cnt_d = scan_cnt_q + 9'd1;
                // Stop advancing at the last entry rather than reading past OAM.
                if ((scan_cnt_q + 9'd1) < 9'(NUM_ENTRIES)) begin
                    oam_addr_d = oam_addr_q + 8'd1;
                end else begin
                    oam_addr_d = oam_addr_q;
                end
                scan_end_s = (scan_cnt_q == 9'(NUM_ENTRIES));
                // The first SCAN cycle has no read data yet.
                if ((scan_cnt_q != 9'd0) && hit_s) begin
                    if (count_q == 4'(MAX_SPRITES)) begin
                        overflow_d = 1'b1;
                        scan_end_s = 1'b1;
                    end else begin
                        list_d[count_q[2:0]] = entry_s;
                        count_d              = count_q + 4'd1;
                    end
                end else begin
                    count_d = count_q;
                end
                if (scan_end_s) begin
                    if (count_d != 4'd0) begin
                        state_d     = ST_FETCH;
                        fetch_cnt_d = 4'd0;
                        gfx_addr_d  = {list_d[0].tile, list_d[0].row};
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end

            ST_FETCH: begin
                // gfx_addr for entry k is on the bus now; its slot write is
                // registered so it lines up with the returning read data.
                if (fetch_cnt_q < count_q) begin
                    slot_we_d   = 1'b1;
                    slot_idx_d  = fetch_cnt_q[2:0];
                    slot_x_d    = list_q[fetch_cnt_q[2:0]].x;
                    slot_pal_d  = list_q[fetch_cnt_q[2:0]].pal;
                    fetch_cnt_d = fetch_nxt_s;
                    if (fetch_nxt_s < count_q) begin
                        gfx_addr_d = {list_q[fetch_nxt_s[2:0]].tile,
                                      list_q[fetch_nxt_s[2:0]].row};
                    end else begin
                        gfx_addr_d = gfx_addr_q;
                    end
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            line_q      <= 10'd0;
            scan_cnt_q  <= 9'd0;
            fetch_cnt_q <= 4'd0;
            count_q     <= 4'd0;
            overflow_q  <= 1'b0;
            oam_addr_q  <= 8'd0;
            gfx_addr_q  <= 11'd0;
            slot_we_q   <= 1'b0;
            slot_idx_q  <= 3'd0;
            slot_x_q    <= 10'd0;
            slot_pal_q  <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                list_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            scan_cnt_q  <= scan_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            oam_addr_q  <= oam_addr_d;
            gfx_addr_q  <= gfx_addr_d;
            slot_we_q   <= slot_we_d;
            slot_idx_q  <= slot_idx_d;
            slot_x_q    <= slot_x_d;
            slot_pal_q  <= slot_pal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                list_q[i] <= list_d[i];
            end
        end
    end

    assign oam_addr_o     = oam_addr_q;
    assign gfx_addr_o     = gfx_addr_q;
    assign slot_we_o      = slot_we_q;
    assign slot_idx_o     = slot_idx_q;
    // Pattern data arrives from memory in the write cycle itself; it is gated
    // so the bus reads zero whenever no slot write is in progress.
    assign slot_pattern_o = slot_we_q ? gfx_rdata_i : 32'd0;
    assign slot_x_o       = slot_x_q;
    assign slot_palette_o = slot_pal_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sprite_count_o = count_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sprite_eval_scheduler.sv
// Self-checking bench for sprite_eval_scheduler: directed scenarios plus
// randomized OAM contents compared against a behavioural line model.
module tb_sprite_eval_scheduler;

    localparam int N     = 64;
    localparam int MAXS  = 8;
    localparam int SPR_H = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  line;
    logic [7:0]  oam_addr;
    logic [31:0] oam_rdata;
    logic [10:0] gfx_addr;
    logic [31:0] gfx_rdata;
    logic        slot_we;
    logic [2:0]  slot_idx;
    logic [31:0] slot_pattern;
    logic [9:0]  slot_x;
    logic [2:0]  slot_palette;
    logic        busy;
    logic        done;
    logic [3:0]  sprite_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0] oam_mem [0:N-1];
    logic [31:0] gfx_mem [0:2047];

    // observations of one run
    int          obs_n;
    logic [2:0]  obs_idx [0:15];
    logic [10:0] obs_addr [0:15];
    logic [31:0] obs_pat [0:15];
    logic [9:0]  obs_x [0:15];
    logic [2:0]  obs_pal [0:15];
    int          done_cyc;
    int          busy_bad;
    logic [3:0]  obs_cnt;
    logic        obs_ovf;

    // model expectations
    int          exp_n;
    int          exp_ovf;
    int          exp_done;
    logic [6:0]  exp_tile [0:7];
    logic [3:0]  exp_row [0:7];
    logic [9:0]  exp_x [0:7];
    logic [2:0]  exp_pal [0:7];

    sprite_eval_scheduler #(.NUM_ENTRIES(N), .MAX_SPRITES(MAXS), .SPRITE_H(SPR_H)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .line_i(line),
        .oam_addr_o(oam_addr), .oam_rdata_i(oam_rdata),
        .gfx_addr_o(gfx_addr), .gfx_rdata_i(gfx_rdata),
        .slot_we_o(slot_we), .slot_idx_o(slot_idx), .slot_pattern_o(slot_pattern),
        .slot_x_o(slot_x), .slot_palette_o(slot_palette),
        .busy_o(busy), .done_o(done), .sprite_count_o(sprite_count), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    // synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        oam_rdata <= oam_mem[oam_addr[5:0]];
        gfx_rdata <= gfx_mem[gfx_addr];
    end

    function automatic logic [31:0] make_oam(input logic en, input logic b30, input logic vf,
                                             input logic [2:0] pal, input logic [6:0] tile,
                                             input logic [9:0] x, input logic [8:0] y);
        return {en, b30, vf, pal, tile, x, y};
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < N; i++) oam_mem[i] = 32'd0;
    endtask

    // Reference: walk OAM in order applying the hit rule and the keep limit.
    task automatic model_line(input logic [9:0] ln);
        int last;
        exp_n = 0; exp_ovf = 0; last = N - 1;
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            int d;
            int r;
            w = oam_mem[i];
            d = int'(ln) - int'(w[8:0]);
            if (w[31] && d >= 0 && d < SPR_H) begin
                if (exp_n == MAXS) begin
                    exp_ovf = 1; last = i;
                    break;
                end
                r = d;
`ifdef SPRITE_VFLIP_EN
                if (w[29]) r = 15 - d;
`endif
                exp_tile[exp_n] = w[25:19];
                exp_row[exp_n]  = 4'(r);
                exp_x[exp_n]    = w[18:9];
                exp_pal[exp_n]  = w[28:26];
                exp_n++;
            end
        end
        // scan covers entries 0..last plus the read-latency cycle, then fetch, then done
        exp_done = (last + 2) + ((exp_n > 0) ? exp_n + 1 : 0) + 1;
    endtask

    // Pulse start and record every slot write until done (bounded).
    task automatic run_line(input logic [9:0] ln, input int mid_cyc, input logic [9:0] mid_ln);
        logic [10:0] prev_gfx;
        @(negedge clk);
        line = ln; start = 1'b1;
        obs_n = 0; done_cyc = -1; busy_bad = 0; obs_cnt = 4'd0; obs_ovf = 1'b0;
        prev_gfx = gfx_addr;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == mid_cyc) begin start = 1'b1; line = mid_ln; end
            else start = 1'b0;
            if (slot_we) begin
                if (obs_n < 16) begin
                    obs_idx[obs_n] = slot_idx; obs_addr[obs_n] = prev_gfx;
                    obs_pat[obs_n] = slot_pattern; obs_x[obs_n] = slot_x;
                    obs_pal[obs_n] = slot_palette;
                end
                obs_n++;
            end
            prev_gfx = gfx_addr;
            if (done) begin
                done_cyc = c; obs_cnt = sprite_count; obs_ovf = overflow;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; line = 10'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({oam_addr, gfx_addr, slot_we, slot_idx, slot_pattern, slot_x, slot_palette,
             busy, done, sprite_count, overflow} !== 74'd0) begin
            failures++; $display("FAIL reset_outputs got busy=%b oam=%0h gfx=%0h cnt=%0d exp all zero",
                                 busy, oam_addr, gfx_addr, sprite_count);
        end
        // start held together with reset must be ignored
        start = 1'b1; line = 10'd5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_wins_start got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_empty();
        clear_oam();
        for (int i = 0; i < N; i++) oam_mem[i] = make_oam(1'b0, 1'b1, 1'b0, 3'd1, 7'd2, 10'd3, 9'd100);
        run_line(10'd100, 0, 10'd0);
        checks++;
        if (done_cyc !== 66) begin failures++; $display("FAIL empty_done got=%0d exp=66", done_cyc); end
        checks++;
        if (obs_n !== 0) begin failures++; $display("FAIL empty_slots got=%0d exp=0", obs_n); end
        checks++;
        if ({obs_cnt, obs_ovf} !== 5'd0) begin
            failures++; $display("FAIL empty_count got cnt=%0d ovf=%b exp 0/0", obs_cnt, obs_ovf);
        end
        checks++;
        if (busy_bad !== 0) begin failures++; $display("FAIL empty_busy got=%0d exp=0", busy_bad); end
    endtask

    task automatic test_single();
        clear_oam();
        oam_mem[5] = make_oam(1'b1, 1'b0, 1'b0, 3'd2, 7'd3, 10'd200, 9'd90);
        run_line(10'd100, 0, 10'd0);
        checks++;
        if (obs_n !== 1) begin failures++; $display("FAIL single_n got=%0d exp=1", obs_n); end
        checks++;
        if (obs_idx[0] !== 3'd0 || obs_addr[0] !== 11'h03A) begin
            failures++; $display("FAIL single_idx_addr got idx=%0d addr=%0h exp 0/03a", obs_idx[0], obs_addr[0]);
        end
        checks++;
        if (obs_x[0] !== 10'd200 || obs_pal[0] !== 3'd2) begin
            failures++; $display("FAIL single_x_pal got x=%0d pal=%0d exp 200/2", obs_x[0], obs_pal[0]);
        end
        checks++;
        if (obs_pat[0] !== gfx_mem[11'h03A]) begin
            failures++; $display("FAIL single_pattern got=%h exp=%h", obs_pat[0], gfx_mem[11'h03A]);
        end
        checks++;
        if (done_cyc !== 68 || obs_cnt !== 4'd1 || obs_ovf !== 1'b0) begin
            failures++; $display("FAIL single_done got cyc=%0d cnt=%0d ovf=%b exp 68/1/0", done_cyc, obs_cnt, obs_ovf);
        end
    endtask

    task automatic setup_overflow();
        clear_oam();
        for (int i = 0; i < 10; i++)
            oam_mem[i] = make_oam(1'b1, 1'b0, 1'b0, 3'(i), 7'(i + 20), 10'(i * 37 + 1), 9'(50 - i));
    endtask

    task automatic check_overflow_run(input string tag);
        checks++;
        if (obs_n !== 8 || obs_cnt !== 4'd8 || obs_ovf !== 1'b1) begin
            failures++; $display("FAIL %s_count got n=%0d cnt=%0d ovf=%b exp 8/8/1", tag, obs_n, obs_cnt, obs_ovf);
        end
        checks++;
        if (done_cyc !== 20) begin failures++; $display("FAIL %s_done got=%0d exp=20", tag, done_cyc); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_idx[k] !== 3'(k) || obs_x[k] !== 10'(k * 37 + 1) || obs_addr[k] !== {7'(k + 20), 4'(k)}) begin
                failures++; $display("FAIL %s_slot%0d got idx=%0d x=%0d addr=%0h exp idx=%0d x=%0d",
                                     tag, k, obs_idx[k], obs_x[k], obs_addr[k], k, k * 37 + 1);
            end
        end
    endtask

    task automatic test_overflow();
        setup_overflow();
        run_line(10'd50, 0, 10'd0);
        check_overflow_run("overflow");
    endtask

    task automatic test_boundaries();
        logic [9:0]  lines [0:3];
        int          exp_hit [0:3];
        logic [10:0] exp_a [0:3];
        lines = '{10'd99, 10'd100, 10'd115, 10'd116};
        exp_hit = '{0, 1, 1, 0};
        exp_a = '{11'h000, 11'h050, 11'h05F, 11'h000};
        clear_oam();
        oam_mem[0] = make_oam(1'b1, 1'b0, 1'b0, 3'd1, 7'd5, 10'd40, 9'd100);
        for (int i = 0; i < 4; i++) begin
            run_line(lines[i], 0, 10'd0);
            checks++;
            if (obs_n !== exp_hit[i] || (exp_hit[i] == 1 && obs_addr[0] !== exp_a[i])) begin
                failures++; $display("FAIL bound_line%0d got n=%0d addr=%0h exp n=%0d addr=%0h",
                                     lines[i], obs_n, obs_addr[0], exp_hit[i], exp_a[i]);
            end
        end
        oam_mem[0] = make_oam(1'b1, 1'b0, 1'b0, 3'd1, 7'd5, 10'd40, 9'd511);
        run_line(10'd0, 0, 10'd0);
        checks++;
        if (obs_n !== 0 || obs_cnt !== 4'd0) begin
            failures++; $display("FAIL bound_nowrap got n=%0d cnt=%0d exp 0/0", obs_n, obs_cnt);
        end
    endtask

    task automatic test_vflip();
        logic [10:0] ea;
`ifdef SPRITE_VFLIP_EN
        ea = 11'h07C;
`else
        ea = 11'h073;
`endif
        clear_oam();
        oam_mem[0] = make_oam(1'b1, 1'b0, 1'b1, 3'd0, 7'd7, 10'd12, 9'd100);
        run_line(10'd103, 0, 10'd0);
        checks++;
        if (obs_n !== 1 || obs_addr[0] !== ea) begin
            failures++; $display("FAIL vflip_addr got n=%0d addr=%0h exp 1/%0h", obs_n, obs_addr[0], ea);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int seen2;
        int bad_after;
        setup_overflow();
        @(negedge clk);
        line = 10'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen2 = 0;
        for (int c = 0; c < 200; c++) begin
            if (slot_we && slot_idx == 3'd2) begin seen2 = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (seen2 !== 1) begin failures++; $display("FAIL rstmid_reach_slot2 got=%0d exp=1", seen2); end
        reset = 1'b1;
        #1;
        checks++;
        if ({oam_addr, gfx_addr, slot_we, slot_idx, slot_pattern, slot_x, slot_palette,
             busy, done, sprite_count, overflow} !== 74'd0) begin
            failures++; $display("FAIL rstmid_outputs got we=%b busy=%b gfx=%0h cnt=%0d exp all zero",
                                 slot_we, busy, gfx_addr, sprite_count);
        end
        bad_after = 0;
        repeat (3) begin
            @(negedge clk);
            if (slot_we || busy || done) bad_after++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (slot_we || busy || done) bad_after++;
        end
        checks++;
        if (bad_after !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", bad_after); end
        run_line(10'd50, 0, 10'd0);
        check_overflow_run("rstmid_rerun");
    endtask

    task automatic test_start_while_busy();
        clear_oam();
        oam_mem[2] = make_oam(1'b1, 1'b0, 1'b0, 3'd1, 7'd9, 10'd300, 9'd200);
        oam_mem[7] = make_oam(1'b1, 1'b0, 1'b0, 3'd4, 7'd11, 10'd50, 9'd400);
        run_line(10'd205, 10, 10'd410);
        checks++;
        if (obs_n !== 1 || obs_addr[0] !== 11'h095 || obs_x[0] !== 10'd300) begin
            failures++; $display("FAIL busy_start_slot got n=%0d addr=%0h x=%0d exp 1/095/300",
                                 obs_n, obs_addr[0], obs_x[0]);
        end
        checks++;
        if (done_cyc !== 68 || obs_cnt !== 4'd1) begin
            failures++; $display("FAIL busy_start_done got cyc=%0d cnt=%0d exp 68/1", done_cyc, obs_cnt);
        end
    endtask

    task automatic test_random();
        logic [9:0] ln;
        int thr;
        for (int it = 0; it < 24; it++) begin
            ln  = 10'($urandom_range(0, 700));
            thr = int'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                oam_mem[i] = make_oam(1'($urandom_range(0, 15) < thr), 1'($urandom_range(0, 1)),
                                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                                      7'($urandom_range(0, 127)), 10'($urandom_range(0, 1023)),
                                      9'(int'(ln) + 10 - int'($urandom_range(0, 40))));
            run_line(ln, 0, 10'd0);
            model_line(ln);
            checks++;
            if (obs_n !== exp_n || obs_cnt !== 4'(exp_n) || obs_ovf !== 1'(exp_ovf)) begin
                failures++; $display("FAIL rand%0d_count got n=%0d cnt=%0d ovf=%b exp n=%0d ovf=%0d",
                                     it, obs_n, obs_cnt, obs_ovf, exp_n, exp_ovf);
            end
            checks++;
            if (done_cyc !== exp_done || busy_bad !== 0) begin
                failures++; $display("FAIL rand%0d_done got cyc=%0d busybad=%0d exp cyc=%0d busybad=0",
                                     it, done_cyc, busy_bad, exp_done);
            end
            for (int k = 0; k < exp_n && k < obs_n; k++) begin
                logic [10:0] ea;
                ea = {exp_tile[k], exp_row[k]};
                checks++;
                if (obs_idx[k] !== 3'(k) || obs_addr[k] !== ea || obs_pat[k] !== gfx_mem[ea] ||
                    obs_x[k] !== exp_x[k] || obs_pal[k] !== exp_pal[k]) begin
                    failures++; $display("FAIL rand%0d_slot%0d got idx=%0d addr=%0h x=%0d pal=%0d exp idx=%0d addr=%0h x=%0d pal=%0d",
                                         it, k, obs_idx[k], obs_addr[k], obs_x[k], obs_pal[k],
                                         k, ea, exp_x[k], exp_pal[k]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) gfx_mem[i] = $urandom;
        for (int i = 0; i < N; i++) oam_mem[i] = 32'd0;
        test_reset();
        test_empty();
        test_single();
        test_overflow();
        test_boundaries();
        test_vflip();
        test_reset_mid_fetch();
        test_start_while_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_eval_scheduler.md
Name: sprite_eval_scheduler

Overview:
Per-scanline sprite evaluation and fetch sequencer for the PPU. On each line-start pulse it scans OAM for sprites that cover the requested line, keeping up to MAX_SPRITES hits. It then fetches each hit's 2bpp pattern row from sprite_graphics and emits one slot-load write per hit. The PPU state machine uses these slot loads to fill the sprite shift registers. It owns the PPU-side read ports of OAM and sprite_graphics while busy.

Parameters:
NUM_ENTRIES, 64, OAM words scanned per line (1..256)
MAX_SPRITES, 8, max sprites kept per line (1..8)
SPRITE_H, 16, sprite height in rows (fixed power of two, 16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin evaluation for line
line  in  10  target scanline, sampled on start
oam_addr  out  8  OAM read address
oam_rdata  in  32  OAM read data, valid 1 cycle after oam_addr
gfx_addr  out  11  sprite_graphics read address
gfx_rdata  in  32  sprite_graphics read data, valid 1 cycle after gfx_addr
slot_we  out  1  slot write strobe
slot_idx  out  3  slot index 0..MAX_SPRITES-1
slot_pattern  out  32  16 px x 2bpp row, px0 in [1:0]
slot_x  out  10  sprite x position
slot_palette  out  3  palette select
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse at end of evaluation
sprite_count  out  4  hits kept this line, stable after done
overflow  out  1  more than MAX_SPRITES hits found

Behaviour:
- OAM word format: [8:0] y, [18:9] x, [25:19] tile, [28:26] palette, [29] vflip (see option), [31] enable; [30] is ignored.
- Hit test: enable=1 and 0 <= line - y <= 15. Compute the difference at 11-bit signed width; a negative difference is a miss, with no wrap.
- row = (line - y)[3:0]; gfx_addr = {tile, row}.
- Reset values: all outputs 0; state IDLE; internal hit list cleared.
- IDLE: on start, latch line, clear sprite_count/overflow, set oam_addr=0, go to SCAN; busy rises next cycle.
- SCAN: pipelined, one entry per cycle. oam_addr increments each cycle, and the entry read the previous cycle is tested.
  - Each hit stores {tile,row,x,palette} in list[count], then count++.
  - A hit arriving when count==MAX_SPRITES sets overflow and ends SCAN immediately; no further entries are tested.
  - Otherwise SCAN ends after entry NUM_ENTRIES-1 is tested, i.e. NUM_ENTRIES+1 cycles.
- FETCH: issue gfx_addr for list[k] each cycle, k = 0..count-1. One cycle later, drive slot_we=1 with slot_idx=k, slot_pattern=gfx_rdata, and slot_x/slot_palette from list[k]. Back-to-back writes, count+1 cycles. count==0 skips FETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE. sprite_count/overflow hold until next start.
- start while busy: ignored.
- start and reset together: reset wins.
- Reset mid-operation: state and outputs cleared asynchronously; no slot writes after reset asserts.
- Outside SCAN/FETCH, oam_addr and gfx_addr hold their last value and slot_we=0.

Optional Feature:
SPRITE_VFLIP_EN
- Defined: when OAM bit 29 = 1, row = 15 - (line - y)[3:0].
- Undefined: bit 29 is ignored; row is always (line - y)[3:0].

Test Plan:
- OAM all enable=0, start line=100 -> no slot_we; done 66 cycles after start (IDLE->SCAN 65 + DONE); sprite_count=0, overflow=0.
- Entry 5 = {en=1,y=90,x=200,tile=3,pal=2}, line=100 -> single slot_we: idx0, gfx_addr=0x03A (tile 3,row 10), slot_x=200, palette=2, pattern equals the memory word.
- Entries 0..9 all hit line 50 -> slots 0..7 written in OAM order; overflow=1; sprite_count=8; scan stops after entry 8 is tested.
- Boundaries: y=100 at lines 99/100/115/116 -> miss/hit row0/hit row15/miss; y=511, line=0 -> miss (no wrap).
- Reset asserted mid-FETCH after slot 2 -> outputs 0 immediately; no further slot_we; next start runs cleanly. A start pulse during busy is ignored.
- With SPRITE_VFLIP_EN: y=100, vflip=1, line=103, tile=7 -> gfx_addr=0x07C (row 12). Without the macro: gfx_addr=0x073.
